// File: rtl/vga_sync_gen_if.sv
// Pixel-side and port-side signals of the VGA timing generator.
// The master drives timing and port signals; the slave supplies the pixel colour.
interface vga_sync_gen_if #(
   parameter int SCREEN_WIDTH = 10,
   parameter int PIXEL_WIDTH  = 12
);
   logic                    p_tick;
   logic [SCREEN_WIDTH-1:0] x;
   logic [SCREEN_WIDTH-1:0] y;
   logic                    video_on;
   logic                    line_start;
   logic                    frame_start;
   logic [PIXEL_WIDTH-1:0]  rgb_in;
   logic                    hsync;
   logic                    vsync;
   logic [PIXEL_WIDTH-1:0]  rgb_out;

   modport master (
      output p_tick, x, y, video_on, line_start, frame_start,
      output hsync, vsync, rgb_out,
      input  rgb_in
   );

   modport slave (
      input  p_tick, x, y, video_on, line_start, frame_start,
      input  hsync, vsync, rgb_out,
      output rgb_in
   );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate enable, scan counters, registered sync/blank decode.
// Define VGA_RGB_REG_EN to register rgb_out and delay hsync/vsync by one pixel.
module vga_sync_gen #(
   parameter int CLK_DIV      = 4,
   parameter int H_DISPLAY    = 640,
   parameter int H_FRONT      = 16,
   parameter int H_SYNC       = 96,
   parameter int H_BACK       = 48,
   parameter int V_DISPLAY    = 480,
   parameter int V_FRONT      = 10,
   parameter int V_SYNC       = 2,
   parameter int V_BACK       = 33,
   parameter int SYNC_ACTIVE  = 0,
   parameter int SCREEN_WIDTH = 10,
   parameter int PIXEL_WIDTH  = 12
) (
   input  logic           sys_clk,
   input  logic           sys_rst_n,
   vga_sync_gen_if.master vga
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [SCREEN_WIDTH-1:0] H_LAST   = SCREEN_WIDTH'(H_TOTAL - 1);
   localparam logic [SCREEN_WIDTH-1:0] V_LAST   = SCREEN_WIDTH'(V_TOTAL - 1);
   localparam logic [SCREEN_WIDTH-1:0] H_VIS    = SCREEN_WIDTH'(H_DISPLAY);
   localparam logic [SCREEN_WIDTH-1:0] V_VIS    = SCREEN_WIDTH'(V_DISPLAY);
   localparam logic [SCREEN_WIDTH-1:0] HS_FIRST = SCREEN_WIDTH'(H_DISPLAY + H_FRONT);
   localparam logic [SCREEN_WIDTH-1:0] HS_LAST  = SCREEN_WIDTH'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [SCREEN_WIDTH-1:0] VS_FIRST = SCREEN_WIDTH'(V_DISPLAY + V_FRONT);
   localparam logic [SCREEN_WIDTH-1:0] VS_LAST  = SCREEN_WIDTH'(V_DISPLAY + V_FRONT + V_SYNC - 1);
   localparam logic                    SYNC_ON  = (SYNC_ACTIVE != 0);

   if (H_TOTAL > (1 << SCREEN_WIDTH)) begin : g_h_total_check
      $error("vga_sync_gen: H_TOTAL does not fit in SCREEN_WIDTH bits");
   end
   if (V_TOTAL > (1 << SCREEN_WIDTH)) begin : g_v_total_check
      $error("vga_sync_gen: V_TOTAL does not fit in SCREEN_WIDTH bits");
   end
   if (CLK_DIV < 1) begin : g_clk_div_check
      $error("vga_sync_gen: CLK_DIV must be at least 1");
   end

   logic [DIV_W-1:0]        div_cnt;
   logic                    p_tick_r;
   logic [SCREEN_WIDTH-1:0] h_cnt;
   logic [SCREEN_WIDTH-1:0] v_cnt;
   logic [SCREEN_WIDTH-1:0] h_next;
   logic [SCREEN_WIDTH-1:0] v_next;
   logic                    h_wrap;
   logic                    v_wrap;
   logic                    video_on_r;
   logic                    line_start_r;
   logic                    frame_start_r;
   logic                    hsync_r;
   logic                    vsync_r;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         div_cnt  <= '0;
         p_tick_r <= 1'b0;
      end else begin
         p_tick_r <= (div_cnt == DIV_LAST);
         div_cnt  <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
      end
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      h_wrap = (h_cnt == H_LAST);
      v_wrap = (v_cnt == V_LAST);
      h_next = h_wrap ? '0 : h_cnt + SCREEN_WIDTH'(1);
      v_next = v_cnt;
      if (h_wrap) begin
         v_next = v_wrap ? '0 : v_cnt + SCREEN_WIDTH'(1);
      end
   end

   // Decode is taken from the next counter values so ports move with x/y on the same edge.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         h_cnt         <= '0;
         v_cnt         <= '0;
         video_on_r    <= 1'b0;
         line_start_r  <= 1'b0;
         frame_start_r <= 1'b0;
         hsync_r       <= ~SYNC_ON;
         vsync_r       <= ~SYNC_ON;
      end else begin
         line_start_r  <= 1'b0;
         frame_start_r <= 1'b0;
         if (p_tick_r) begin
            h_cnt         <= h_next;
            v_cnt         <= v_next;
            video_on_r    <= (h_next < H_VIS) && (v_next < V_VIS);
            hsync_r       <= (h_next >= HS_FIRST && h_next <= HS_LAST) ? SYNC_ON : ~SYNC_ON;
            vsync_r       <= (v_next >= VS_FIRST && v_next <= VS_LAST) ? SYNC_ON : ~SYNC_ON;
            line_start_r  <= h_wrap;
            frame_start_r <= h_wrap && v_wrap;
         end
      end
   end

   assign vga.p_tick      = p_tick_r;
   assign vga.x           = h_cnt;
   assign vga.y           = v_cnt;
   assign vga.video_on    = video_on_r;
   assign vga.line_start  = line_start_r;
   assign vga.frame_start = frame_start_r;

`ifdef VGA_RGB_REG_EN
   logic [PIXEL_WIDTH-1:0] rgb_q;
   logic                   hsync_q;
   logic                   vsync_q;

   // Colour and syncs share one pixel of delay so they stay aligned at the port.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rgb_q   <= '0;
         hsync_q <= ~SYNC_ON;
         vsync_q <= ~SYNC_ON;
      end else if (p_tick_r) begin
         rgb_q   <= video_on_r ? vga.rgb_in : '0;
         hsync_q <= hsync_r;
         vsync_q <= vsync_r;
      end
   end

   assign vga.rgb_out = rgb_q;
   assign vga.hsync   = hsync_q;
   assign vga.vsync   = vsync_q;
`else
   assign vga.rgb_out = video_on_r ? vga.rgb_in : '0;
   assign vga.hsync   = hsync_r;
   assign vga.vsync   = vsync_r;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: two reduced-size instances (divide-by-4 active-low syncs,
// divide-by-1 active-high syncs) checked cycle by cycle against a pixel-index model.
module tb_vga_sync_gen;

   localparam int HD = 16, HF = 4, HS = 6, HB = 4;
   localparam int VD = 10, VF = 2, VS = 2, VB = 3;
   localparam int HT = HD + HF + HS + HB;
   localparam int VT = VD + VF + VS + VB;
   localparam int FT = HT * VT;
   localparam int SW = 10, PW = 12;
   localparam int DIV_A = 4, DIV_B = 1;

   typedef struct packed {
      logic          p_tick;
      logic [SW-1:0] x;
      logic [SW-1:0] y;
      logic          video_on;
      logic          line_start;
      logic          frame_start;
      logic          hsync;
      logic          vsync;
      logic [PW-1:0] rgb;
   } obs_t;

   logic          sys_clk = 1'b0;
   logic          sys_rst_n;
   logic [PW-1:0] rgb_val;

   int errors   = 0;
   int checks   = 0;
   int edge_cnt = 0;
   int fs_a = 0, ls_a = 0, fs_b = 0, ls_b = 0;

   obs_t q_a[$];
   obs_t q_b[$];

   vga_sync_gen_if #(.SCREEN_WIDTH(SW), .PIXEL_WIDTH(PW)) bus_a ();
   vga_sync_gen_if #(.SCREEN_WIDTH(SW), .PIXEL_WIDTH(PW)) bus_b ();

   assign bus_a.rgb_in = rgb_val;
   assign bus_b.rgb_in = rgb_val;

   vga_sync_gen #(
      .CLK_DIV(DIV_A), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .SYNC_ACTIVE(0), .SCREEN_WIDTH(SW), .PIXEL_WIDTH(PW)
   ) dut_a (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .vga(bus_a)
   );

   vga_sync_gen #(
      .CLK_DIV(DIV_B), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .SYNC_ACTIVE(1), .SCREEN_WIDTH(SW), .PIXEL_WIDTH(PW)
   ) dut_b (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .vga(bus_b)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached (errors=%0d checks=%0d)", errors, checks);
      $fatal(1, "watchdog");
   end

   // Pixel index n counts advances since reset; n = 0 is the reset position.
   function automatic bit vis(int n);
      if (n < 1) return 1'b0;
      return ((n % HT) < HD) && (((n / HT) % VT) < VD);
   endfunction

   function automatic bit hs_on(int n);
      int h;
      if (n < 1) return 1'b0;
      h = n % HT;
      return (h >= HD + HF) && (h < HD + HF + HS);
   endfunction

   function automatic bit vs_on(int n);
      int v;
      if (n < 1) return 1'b0;
      v = (n / HT) % VT;
      return (v >= VD + VF) && (v < VD + VF + VS);
   endfunction

   // Expected outputs after the e-th rising edge since reset release (e = 0: in reset).
   function automatic obs_t model(int e, int d, bit act, logic [PW-1:0] rgb);
      obs_t o;
      int   n, pn;
      n             = (e >= 1) ? (e - 1) / d : 0;
      o.p_tick      = (e >= d) && (e % d == 0);
      o.x           = SW'(n % HT);
      o.y           = SW'((n / HT) % VT);
      o.video_on    = vis(n);
      o.line_start  = (n >= 1) && ((e - 1) % d == 0) && (n % HT == 0);
      o.frame_start = o.line_start && ((n / HT) % VT == 0);
`ifdef VGA_RGB_REG_EN
      pn = n - 1;
`else
      pn = n;
`endif
      o.hsync = hs_on(pn) ? act : ~act;
      o.vsync = vs_on(pn) ? act : ~act;
      o.rgb   = vis(pn) ? rgb : '0;
      return o;
   endfunction

   function automatic obs_t sample_a();
      obs_t o;
      o.p_tick = bus_a.p_tick; o.x = bus_a.x; o.y = bus_a.y;
      o.video_on = bus_a.video_on; o.line_start = bus_a.line_start;
      o.frame_start = bus_a.frame_start; o.hsync = bus_a.hsync;
      o.vsync = bus_a.vsync; o.rgb = bus_a.rgb_out;
      return o;
   endfunction

   function automatic obs_t sample_b();
      obs_t o;
      o.p_tick = bus_b.p_tick; o.x = bus_b.x; o.y = bus_b.y;
      o.video_on = bus_b.video_on; o.line_start = bus_b.line_start;
      o.frame_start = bus_b.frame_start; o.hsync = bus_b.hsync;
      o.vsync = bus_b.vsync; o.rgb = bus_b.rgb_out;
      return o;
   endfunction

   function automatic string fmt(obs_t o);
      return $sformatf("tick=%b x=%0d y=%0d von=%b ls=%b fs=%b hs=%b vs=%b rgb=%h",
                       o.p_tick, o.x, o.y, o.video_on, o.line_start, o.frame_start,
                       o.hsync, o.vsync, o.rgb);
   endfunction

   // Scoreboard: expectations are queued at each edge and retired at the following falling edge.
   task automatic scan_cycles(input string tag, input int ncyc);
      obs_t got, exp_o;
      for (int i = 0; i < ncyc; i++) begin
         @(posedge sys_clk);
         edge_cnt++;
         q_a.push_back(model(edge_cnt, DIV_A, 1'b0, rgb_val));
         q_b.push_back(model(edge_cnt, DIV_B, 1'b1, rgb_val));
         @(negedge sys_clk);
         got   = sample_a();
         exp_o = q_a.pop_front();
         checks++;
         if (got !== exp_o) begin
            errors++;
            $display("FAIL %s dut_a edge %0d: got {%s} expected {%s}", tag, edge_cnt, fmt(got), fmt(exp_o));
         end
         got   = sample_b();
         exp_o = q_b.pop_front();
         checks++;
         if (got !== exp_o) begin
            errors++;
            $display("FAIL %s dut_b edge %0d: got {%s} expected {%s}", tag, edge_cnt, fmt(got), fmt(exp_o));
         end
         if (bus_a.frame_start === 1'b1) fs_a++;
         if (bus_a.line_start  === 1'b1) ls_a++;
         if (bus_b.frame_start === 1'b1) fs_b++;
         if (bus_b.line_start  === 1'b1) ls_b++;
      end
   endtask

   task automatic release_reset();
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      edge_cnt  = 0;
      fs_a = 0; ls_a = 0; fs_b = 0; ls_b = 0;
   endtask

   task automatic test_reset();
      obs_t got;
      sys_rst_n = 1'b0;
      rgb_val   = 12'hABC;
      repeat (5) @(posedge sys_clk);
      @(negedge sys_clk);
      got = sample_a();
      checks++;
      if (got !== model(0, DIV_A, 1'b0, rgb_val)) begin
         errors++;
         $display("FAIL reset dut_a: got {%s} expected {%s}", fmt(got), fmt(model(0, DIV_A, 1'b0, rgb_val)));
      end
      got = sample_b();
      checks++;
      if (got !== model(0, DIV_B, 1'b1, rgb_val)) begin
         errors++;
         $display("FAIL reset dut_b: got {%s} expected {%s}", fmt(got), fmt(model(0, DIV_B, 1'b1, rgb_val)));
      end
      release_reset();
   endtask

   // Two full frames plus part of a third: wraps, sync windows, blanking, pulse counts.
   task automatic test_scan(input string tag);
      int na, nb;
      scan_cycles(tag, DIV_A * (2 * FT + 40) + 1);
      na = (edge_cnt - 1) / DIV_A;
      nb = (edge_cnt - 1) / DIV_B;
      checks++;
      if (fs_a !== na / FT) begin
         errors++;
         $display("FAIL %s frame_start count dut_a: got %0d expected %0d", tag, fs_a, na / FT);
      end
      checks++;
      if (ls_a !== na / HT) begin
         errors++;
         $display("FAIL %s line_start count dut_a: got %0d expected %0d", tag, ls_a, na / HT);
      end
      checks++;
      if (fs_b !== nb / FT) begin
         errors++;
         $display("FAIL %s frame_start count dut_b: got %0d expected %0d", tag, fs_b, nb / FT);
      end
      checks++;
      if (ls_b !== nb / HT) begin
         errors++;
         $display("FAIL %s line_start count dut_b: got %0d expected %0d", tag, ls_b, nb / HT);
      end
   endtask

   task automatic test_mid_reset();
      int   n_now, n_t;
      obs_t got;
      n_now = (edge_cnt - 1) / DIV_A;
      n_t   = (n_now / FT) * FT + 5 * HT + 10;
      if (n_t <= n_now) n_t += FT;
      scan_cycles("approach", DIV_A * n_t + 1 - edge_cnt);
      checks++;
      if (bus_a.x !== SW'(10) || bus_a.y !== SW'(5)) begin
         errors++;
         $display("FAIL mid_reset position: got x=%0d y=%0d expected x=10 y=5", bus_a.x, bus_a.y);
      end
      #3;
      sys_rst_n = 1'b0;
      #1;
      got = sample_a();
      checks++;
      if (got !== model(0, DIV_A, 1'b0, rgb_val)) begin
         errors++;
         $display("FAIL mid_reset async dut_a: got {%s} expected {%s}", fmt(got), fmt(model(0, DIV_A, 1'b0, rgb_val)));
      end
      got = sample_b();
      checks++;
      if (got !== model(0, DIV_B, 1'b1, rgb_val)) begin
         errors++;
         $display("FAIL mid_reset async dut_b: got {%s} expected {%s}", fmt(got), fmt(model(0, DIV_B, 1'b1, rgb_val)));
      end
      repeat (3) @(posedge sys_clk);
      release_reset();
      test_scan("restart");
   endtask

   task automatic test_colour();
      @(negedge sys_clk);
      sys_rst_n = 1'b0;
      rgb_val   = 12'h5A3;
      repeat (2) @(posedge sys_clk);
      release_reset();
      scan_cycles("colour", DIV_A * (3 * HT + 5) + 1);
   endtask

   initial begin
      rgb_val   = '0;
      sys_rst_n = 1'b0;
      test_reset();
      test_scan("scan");
      test_mid_reset();
      test_colour();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
